gpio_bank: RTL and testbench

Parametrised, bus-attached general-purpose I/O peripheral that replaces the single fixed 8-bit output port on the CPU's shared memory bus. It provides CHANNELS independent ports of WIDTH bits, each with per-bit direction control, atomic set/clear/toggle writes, input synchronisers, sticky change-detect flags and a combined interrupt line. It sits beside the core and RAM on the read/write bus and answers only inside its own address window.

---
 rtl/gpio_bank_if.sv | 19 +
 rtl/gpio_bank.sv | 130 +++++++++++++
 tb/tb_gpio_bank.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_if.sv
// Read/write memory-bus bundle shared by the core, RAM and bus-attached peripherals.
// Reads are answered with registered data; non-selected slaves drive zero (OR-combined bus).
interface gpio_bank_if;
   logic [15:0] read_addr;
   logic [15:0] read_data;
   logic [15:0] write_addr;
   logic [15:0] write_data;
   logic        write_strobe;

   modport master (
      output read_addr, write_addr, write_data, write_strobe,
      input  read_data
   );

   modport slave (
      input  read_addr, write_addr, write_data, write_strobe,
      output read_data
   );
endinterface

// File: rtl/gpio_bank.sv
// Multi-channel GPIO peripheral: OUT/SET/CLR/TOG/DIR/IN/EDGE/EDGE_EN per channel,
// synchronised inputs with sticky change flags and a combined registered interrupt.
module gpio_bank #(
   parameter logic [15:0] BASE_ADDR = 16'hFF00,
   parameter int unsigned CHANNELS  = 1,
   parameter int unsigned WIDTH     = 8
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   gpio_bank_if.slave                bus,
   input  logic [CHANNELS*WIDTH-1:0] pins_in,
   output logic [CHANNELS*WIDTH-1:0] pins_out,
   output logic [CHANNELS*WIDTH-1:0] pins_oe,
   output logic                      irq
);

   logic [WIDTH-1:0] out_q       [CHANNELS];
   logic [WIDTH-1:0] out_d       [CHANNELS];
   logic [WIDTH-1:0] dir_q       [CHANNELS];
   logic [WIDTH-1:0] dir_d       [CHANNELS];
   logic [WIDTH-1:0] edge_flag_q [CHANNELS];
   logic [WIDTH-1:0] edge_flag_d [CHANNELS];
   logic [WIDTH-1:0] edge_en_q   [CHANNELS];
   logic [WIDTH-1:0] edge_en_d   [CHANNELS];
   logic [WIDTH-1:0] sync1_q     [CHANNELS];
   logic [WIDTH-1:0] sync1_d     [CHANNELS];
   logic [WIDTH-1:0] sync2_q     [CHANNELS];
   logic [WIDTH-1:0] sync2_d     [CHANNELS];
   logic [WIDTH-1:0] prev_q      [CHANNELS];
   logic [WIDTH-1:0] prev_d      [CHANNELS];
   logic [1:0]       warm_q, warm_d;
   logic [15:0]      read_data_q, read_data_d;
   logic             irq_q, irq_d;

   logic             wr_hit, rd_hit, detect_en;
   logic [2:0]       wr_ch, wr_off, rd_ch, rd_off;
   logic [WIDTH-1:0] wdata;

   // The window is 64 aligned addresses, so only the upper ten bits select it.
   assign wr_hit    = bus.write_strobe && (bus.write_addr[15:6] == BASE_ADDR[15:6]);
   assign rd_hit    = bus.read_addr[15:6] == BASE_ADDR[15:6];
   assign wr_ch     = bus.write_addr[5:3];
   assign wr_off    = bus.write_addr[2:0];
   assign rd_ch     = bus.read_addr[5:3];
   assign rd_off    = bus.read_addr[2:0];
   assign wdata     = bus.write_data[WIDTH-1:0];
   assign detect_en = warm_q == 2'd3;
   assign warm_d    = detect_en ? warm_q : warm_q + 2'd1;

   always_comb begin
      irq_d       = 1'b0;
      read_data_d = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         out_d[c]       = out_q[c];
         dir_d[c]       = dir_q[c];
         edge_flag_d[c] = edge_flag_q[c];
         edge_en_d[c]   = edge_en_q[c];
         sync1_d[c]     = pins_in[c*WIDTH +: WIDTH];
         sync2_d[c]     = sync1_q[c];
         prev_d[c]      = sync2_q[c];

         if (wr_hit && (int'(wr_ch) == c)) begin
            unique case (wr_off)
               3'd0:    out_d[c]       = wdata;
               3'd1:    out_d[c]       = out_q[c] | wdata;
               3'd2:    out_d[c]       = out_q[c] & ~wdata;
               3'd3:    out_d[c]       = out_q[c] ^ wdata;
               3'd4:    dir_d[c]       = wdata;
               3'd6:    edge_flag_d[c] = edge_flag_q[c] & ~wdata;
               3'd7:    edge_en_d[c]   = wdata;
               default: ;
            endcase
         end

         // Applied after the W1C so a simultaneous change keeps the flag set.
         if (detect_en) begin
            edge_flag_d[c] = edge_flag_d[c] | (sync2_q[c] ^ prev_q[c]);
         end

         irq_d = irq_d | (|(edge_flag_q[c] & edge_en_q[c]));

         if (rd_hit && (int'(rd_ch) == c)) begin
            unique case (rd_off)
               3'd0, 3'd1, 3'd2, 3'd3: read_data_d[WIDTH-1:0] = out_q[c];
               3'd4:                   read_data_d[WIDTH-1:0] = dir_q[c];
               3'd5:                   read_data_d[WIDTH-1:0] = sync2_q[c];
               3'd6:                   read_data_d[WIDTH-1:0] = edge_flag_q[c];
               3'd7:                   read_data_d[WIDTH-1:0] = edge_en_q[c];
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            out_q[c]       <= '0;
            dir_q[c]       <= '0;
            edge_flag_q[c] <= '0;
            edge_en_q[c]   <= '0;
            sync1_q[c]     <= '0;
            sync2_q[c]     <= '0;
            prev_q[c]      <= '0;
         end
         warm_q      <= '0;
         read_data_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         out_q       <= out_d;
         dir_q       <= dir_d;
         edge_flag_q <= edge_flag_d;
         edge_en_q   <= edge_en_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         warm_q      <= warm_d;
         read_data_q <= read_data_d;
         irq_q       <= irq_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_flat
      assign pins_out[g*WIDTH +: WIDTH] = out_q[g];
      assign pins_oe[g*WIDTH +: WIDTH]  = dir_q[g];
   end

   assign bus.read_data = read_data_q;
   assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboarded bench for gpio_bank: reads push model predictions, a monitor pops and
// compares when the registered read data appears; random traffic plus directed corner cases.
module tb_gpio_bank;
   localparam int          CH   = 3;
   localparam int          W    = 8;
   localparam logic [15:0] BASE = 16'hFF00;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH*W-1:0] pins_in;
   logic [CH*W-1:0] pins_out;
   logic [CH*W-1:0] pins_oe;
   logic            irq;

   gpio_bank_if bus_if ();

   gpio_bank #(.BASE_ADDR(BASE), .CHANNELS(CH), .WIDTH(W)) dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .bus      (bus_if.slave),
      .pins_in  (pins_in),
      .pins_out (pins_out),
      .pins_oe  (pins_oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   // Reference model: register contents as the programmer sees them.
   logic [W-1:0] m_out [CH];
   logic [W-1:0] m_dir [CH];
   logic [W-1:0] m_edge[CH];
   logic [W-1:0] m_en  [CH];
   logic [W-1:0] m_in  [CH];

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [15:0] exp_q[$];
   string       name_q[$];
   logic        rd_flag  = 1'b0;
   logic        rd_valid = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic logic [15:0] addr_of(input int ch, input int off);
      return BASE + 16'(8 * ch + off);
   endfunction

   function automatic logic [15:0] model_read(input logic [15:0] a);
      int rel = int'(a) - int'(BASE);
      int ch, off;
      logic [W-1:0] v;
      if (rel < 0 || rel >= 64) return 16'h0;
      ch  = rel / 8;
      off = rel % 8;
      if (ch >= CH) return 16'h0;
      case (off)
         4:       v = m_dir[ch];
         5:       v = m_in[ch];
         6:       v = m_edge[ch];
         7:       v = m_en[ch];
         default: v = m_out[ch];
      endcase
      return 16'(v);
   endfunction

   task automatic model_write(input logic [15:0] a, input logic [15:0] data);
      int rel = int'(a) - int'(BASE);
      int ch, off;
      logic [W-1:0] d = W'(data);
      if (rel < 0 || rel >= 64) return;
      ch  = rel / 8;
      off = rel % 8;
      if (ch >= CH) return;
      case (off)
         0: m_out[ch]  = d;
         1: m_out[ch]  = m_out[ch] | d;
         2: m_out[ch]  = m_out[ch] & ~d;
         3: m_out[ch]  = m_out[ch] ^ d;
         4: m_dir[ch]  = d;
         6: m_edge[ch] = m_edge[ch] & ~d;
         7: m_en[ch]   = d;
         default: ;
      endcase
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_out[c] = '0; m_dir[c] = '0; m_edge[c] = '0; m_en[c] = '0; m_in[c] = '0;
      end
   endtask

   function automatic logic [CH*W-1:0] model_pins_out();
      logic [CH*W-1:0] v;
      for (int c = 0; c < CH; c++) v[c*W +: W] = m_out[c];
      return v;
   endfunction

   function automatic logic [CH*W-1:0] model_pins_oe();
      logic [CH*W-1:0] v;
      for (int c = 0; c < CH; c++) v[c*W +: W] = m_dir[c];
      return v;
   endfunction

   function automatic logic model_irq();
      logic r = 1'b0;
      for (int c = 0; c < CH; c++) r = r | (|(m_edge[c] & m_en[c]));
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_op(input bit we, input logic [15:0] wa, input logic [15:0] wd,
                         input bit re, input logic [15:0] ra, input string nm);
      if (re) begin
         exp_q.push_back(model_read(ra));
         name_q.push_back(nm);
         bus_if.read_addr = ra;
         rd_flag = 1'b1;
      end
      bus_if.write_strobe = we;
      bus_if.write_addr   = wa;
      bus_if.write_data   = wd;
      tick();
      if (we) model_write(wa, wd);
      bus_if.write_strobe = 1'b0;
      rd_flag = 1'b0;
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      bus_op(1'b1, a, d, 1'b0, 16'h0, "");
   endtask

   task automatic rd(input logic [15:0] a, input string nm);
      bus_op(1'b0, 16'h0, 16'h0, 1'b1, a, nm);
   endtask

   // Change pins and let them settle; every bit that moved raises its sticky flag.
   task automatic set_pins(input logic [CH*W-1:0] p);
      logic [CH*W-1:0] old = pins_in;
      pins_in = p;
      repeat (6) tick();
      for (int c = 0; c < CH; c++) begin
         m_edge[c] = m_edge[c] | (old[c*W +: W] ^ p[c*W +: W]);
         m_in[c]   = p[c*W +: W];
      end
   endtask

   // Monitor: read data is valid the cycle after a read was presented.
   always @(posedge clk) rd_valid <= rd_flag;

   always @(negedge clk) begin
      if (rd_valid) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_underflow: got read 0x%0h expected none", bus_if.read_data);
         end else begin
            check(name_q.pop_front(), 32'(bus_if.read_data), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bus_if.read_addr    = 16'h0;
      bus_if.write_addr   = 16'h0;
      bus_if.write_data   = 16'h0;
      bus_if.write_strobe = 1'b0;
      pins_in = '1;
      model_reset();

      // Pins held high through reset must not raise flags.
      repeat (3) tick();
      rst_n = 1'b1;
      for (int c = 0; c < CH; c++) m_in[c] = '1;
      repeat (10) tick();
      check("reset_pins_out", 32'(pins_out), 32'(model_pins_out()));
      check("reset_pins_oe", 32'(pins_oe), 32'(model_pins_oe()));
      check("reset_irq", 32'(irq), 32'(model_irq()));
      rd(addr_of(0, 6), "reset_edge_ch0");
      rd(addr_of(0, 5), "reset_in_ch0");
      rd(addr_of(2, 6), "reset_edge_ch2");

      // Atomic OUT manipulation and direction.
      wr(addr_of(0, 0), 16'h000F);
      wr(addr_of(0, 1), 16'h00F0);
      wr(addr_of(0, 2), 16'h0003);
      wr(addr_of(0, 3), 16'hFF81);
      rd(addr_of(0, 0), "out_ch0_after_ops");
      check("pins_out_ch0", 32'(pins_out[7:0]), 32'(m_out[0]));
      wr(addr_of(0, 4), 16'h00AA);
      check("pins_oe_ch0", 32'(pins_oe), 32'(model_pins_oe()));

      // Same-cycle read and write returns the old value.
      bus_op(1'b1, addr_of(2, 0), 16'h0055, 1'b1, addr_of(2, 0), "rd_during_wr_ch2");
      rd(addr_of(2, 0), "out_ch2");
      rd(addr_of(1, 0), "out_ch1");
      rd(16'h1234, "outside_window");
      rd(addr_of(5, 0), "unused_channel");
      check("pins_out_all", 32'(pins_out), 32'(model_pins_out()));

      // Drop all pins, clear the resulting flags, then exercise the irq path.
      set_pins('0);
      rd(addr_of(1, 6), "edge_ch1_after_drop");
      for (int c = 0; c < CH; c++) wr(addr_of(c, 6), 16'h00FF);
      wr(addr_of(1, 7), 16'h0001);
      tick();
      check("irq_masked_clear", 32'(irq), 32'(model_irq()));

      pins_in[8] = 1'b1;
      repeat (3) tick();
      pins_in[8] = 1'b0;
      check("irq_before_latency", 32'(irq), 32'h0);
      tick();
      check("irq_at_latency", 32'(irq), 32'h1);
      repeat (6) tick();
      m_edge[1][0] = 1'b1;
      rd(addr_of(1, 6), "edge_ch1_pulse");
      check("irq_after_pulse", 32'(irq), 32'(model_irq()));

      wr(addr_of(1, 6), 16'h0001);
      check("irq_lags_w1c", 32'(irq), 32'h1);
      tick();
      check("irq_after_w1c", 32'(irq), 32'(model_irq()));

      // W1C lands on the same edge the change is detected: flag must survive.
      pins_in[8] = 1'b1;
      tick();
      tick();
      wr(addr_of(1, 6), 16'h0001);
      m_edge[1][0] = 1'b1;
      repeat (6) tick();
      m_in[1] = pins_in[15:8];
      rd(addr_of(1, 6), "edge_set_wins");
      rd(addr_of(1, 5), "in_ch1");
      check("irq_set_wins", 32'(irq), 32'(model_irq()));

      // Random register traffic with static pins.
      for (int i = 0; i < 120; i++) begin
         logic [15:0] wa, ra, wd;
         int kind = int'($urandom_range(0, 2));
         wa = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 32'hFEFF))
                                          : addr_of(int'($urandom_range(0, 3)),
                                                    int'($urandom_range(0, 7)));
         ra = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 32'hFEFF))
                                          : addr_of(int'($urandom_range(0, 3)),
                                                    int'($urandom_range(0, 7)));
         wd = 16'($urandom);
         bus_op(kind != 1, wa, wd, kind != 0, ra, "rand_read");
         if (kind != 1) begin
            check("rand_pins_out", 32'(pins_out), 32'(model_pins_out()));
            check("rand_pins_oe", 32'(pins_oe), 32'(model_pins_oe()));
         end
      end
      tick();
      tick();
      check("rand_irq", 32'(irq), 32'(model_irq()));

      // Asynchronous reset with live state.
      set_pins(pins_in ^ 24'h000200);
      wr(addr_of(1, 7), 16'h00FF);
      wr(addr_of(0, 0), 16'h00A5);
      wr(addr_of(0, 4), 16'h003C);
      tick();
      tick();
      check("pre_reset_irq", 32'(irq), 32'h1);
      rd(addr_of(0, 0), "pre_reset_read");
      #6;
      rst_n = 1'b0;
      #1;
      check("async_irq", 32'(irq), 32'h0);
      check("async_pins_out", 32'(pins_out), 32'h0);
      check("async_pins_oe", 32'(pins_oe), 32'h0);
      check("async_read_data", 32'(bus_if.read_data), 32'h0);
      model_reset();
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < CH; c++) m_in[c] = pins_in[c*W +: W];
      repeat (8) tick();
      rd(addr_of(0, 0), "post_reset_out");
      rd(addr_of(1, 6), "post_reset_edge_ch1");
      rd(addr_of(1, 5), "post_reset_in_ch1");
      tick();
      tick();

      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_leftover: got %0d pending expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
